// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: fetch FSM states, widths, bubble word.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] NOP_BUBBLE   = '0;
  localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0;

  typedef enum logic [2:0] {
    ST_REQ0  = 3'd0,
    ST_REQ1  = 3'd1,
    ST_REQ2  = 3'd2,
    ST_REQ3  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HOLD  = 3'd5
  } fetch_state_e;

  function automatic logic is_req(input fetch_state_e s);
    return (s == ST_REQ0) || (s == ST_REQ1) || (s == ST_REQ2) || (s == ST_REQ3);
  endfunction

  function automatic logic [1:0] req_lane(input fetch_state_e s);
    logic [1:0] lane;
    case (s)
      ST_REQ1: lane = 2'd1;
      ST_REQ2: lane = 2'd2;
      ST_REQ3: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundles: byte-wide memory read port and the fetch/decode link.
interface fetch_mem_if;
  logic        mem_gnt;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_rd;

  modport master (output mem_a, mem_rd, input mem_gnt, mem_din);
  modport slave  (input mem_a, mem_rd, output mem_gnt, mem_din);
endinterface

interface fetch_id_if;
  logic        id_if_pce;
  logic [31:0] id_if_pc;
  logic [31:0] id_if_off;
  logic        id_stall;
  logic [31:0] if_pc;
  logic [31:0] if_is;
  logic        if_vld;

  modport master (output if_pc, if_is, if_vld,
                  input  id_if_pce, id_if_pc, id_if_off, id_stall);
  modport slave  (input  if_pc, if_is, if_vld,
                  output id_if_pce, id_if_pc, id_if_off, id_stall);
endinterface

// File: rtl/if_fetch_byte_asm.sv
// Four-lane little-endian byte buffer; o_word already includes the byte landing this cycle.
module if_byte_asm
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_cap_en,
  input  logic [1:0]        i_lane,
  input  logic [BYTE_W-1:0] i_din,
  output logic [INST_W-1:0] o_word
);

  logic [INST_W-1:0] r_buf;
  logic [INST_W-1:0] w_merged;

  always_comb begin
    w_merged = r_buf;
    if (i_cap_en) begin
      w_merged[{i_lane, 3'b000} +: BYTE_W] = i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (i_clr) begin
      r_buf <= '0;
    end else begin
      r_buf <= w_merged;
    end
  end

  assign o_word = w_merged;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads per word, then present to decode until accepted.
// States: REQ0..REQ3 request byte k | DRAIN last byte lands | HOLD word presented to decode.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_mem_if.master mem,
  fetch_id_if.master  id
);

  fetch_state_e      r_state, w_state_nxt;
  logic [INST_W-1:0] r_pc, w_pc_nxt;
  logic              r_pend, w_pend_nxt;
  logic [1:0]        r_pidx, w_pidx_nxt;
  logic              r_vld, w_vld_nxt;
  logic [INST_W-1:0] r_is, w_is_nxt;
  logic [INST_W-1:0] r_opc, w_opc_nxt;

  logic              w_req;
  logic [1:0]        w_lane;
  logic [INST_W-1:0] w_word;

  assign w_req  = is_req(r_state);
  assign w_lane = req_lane(r_state);

  if_byte_asm u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (id.id_if_pce),
    .i_cap_en (r_pend),
    .i_lane   (r_pidx),
    .i_din    (mem.mem_din),
    .o_word   (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ0;
      r_pc    <= RESET_PC;
      r_pend  <= 1'b0;
      r_pidx  <= 2'd0;
      r_vld   <= 1'b0;
      r_is    <= NOP_BUBBLE;
      r_opc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      r_pidx  <= w_pidx_nxt;
      r_vld   <= w_vld_nxt;
      r_is    <= w_is_nxt;
      r_opc   <= w_opc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = 1'b0;
    w_pidx_nxt  = r_pidx;
    w_vld_nxt   = r_vld;
    w_is_nxt    = r_is;
    w_opc_nxt   = r_opc;

    if (id.id_if_pce) begin
      // Redirect wins over everything; any in-flight byte and held word are dropped.
      w_state_nxt = ST_REQ0;
      w_pc_nxt    = id.id_if_off + id.id_if_pc;
      w_vld_nxt   = 1'b0;
      w_is_nxt    = NOP_BUBBLE;
    end else begin
      case (r_state)
        ST_REQ0, ST_REQ1, ST_REQ2, ST_REQ3: begin
          if (mem.mem_gnt) begin
            w_pend_nxt = 1'b1;
            w_pidx_nxt = w_lane;
            case (r_state)
              ST_REQ0: w_state_nxt = ST_REQ1;
              ST_REQ1: w_state_nxt = ST_REQ2;
              ST_REQ2: w_state_nxt = ST_REQ3;
              default: w_state_nxt = ST_DRAIN;
            endcase
          end
        end
        ST_DRAIN: begin
          w_state_nxt = ST_HOLD;
          w_vld_nxt   = 1'b1;
          w_is_nxt    = w_word;
          w_opc_nxt   = r_pc;
        end
        ST_HOLD: begin
          if (!id.id_stall) begin
            w_state_nxt = ST_REQ0;
            w_pc_nxt    = r_pc + 32'd4;
            w_vld_nxt   = 1'b0;
            w_is_nxt    = NOP_BUBBLE;
          end
        end
        default: begin
          w_state_nxt = ST_REQ0;
        end
      endcase
    end
  end

  // Request outputs are decoded from state, so they are forced low while reset is held.
  assign mem.mem_rd = rst_n & w_req;
  assign mem.mem_a  = rst_n ? (r_pc + {30'b0, w_lane}) : '0;

  assign id.if_vld = r_vld;
  assign id.if_is  = r_is;
  assign id.if_pc  = r_opc;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random grant/stall/redirect against a word-level model.
module tb_if_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_mem_if u_mem ();
  fetch_id_if  u_id ();

  if_fetch #(.RESET_PC(32'h0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem   (u_mem),
    .id    (u_id)
  );

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  // model: fetch pc, bytes accepted so far, presented word valid, presented pc
  logic [31:0] m_pc;
  logic [31:0] m_opc;
  logic        m_vld;
  int          m_cnt;

  // memory answers the cycle after an accepted request, otherwise drives junk
  always @(posedge clk) begin
    if (u_mem.mem_rd && u_mem.mem_gnt) u_mem.mem_din <= mem[u_mem.mem_a[7:0]];
    else u_mem.mem_din <= 8'($urandom);
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] i0, i1, i2, i3;
    i0 = a[7:0];
    i1 = i0 + 8'd1;
    i2 = i0 + 8'd2;
    i3 = i0 + 8'd3;
    return {mem[i3], mem[i2], mem[i1], mem[i0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_opc = 32'h0;
    m_vld = 1'b0;
    m_cnt = 0;
  endtask

  task automatic drive_check(input logic gnt, input logic stall, input logic pce,
                             input logic [31:0] off, input logic [31:0] pcv);
    logic req;
    u_mem.mem_gnt   = gnt;
    u_id.id_stall   = stall;
    u_id.id_if_pce  = pce;
    u_id.id_if_off  = off;
    u_id.id_if_pc   = pcv;
    #1;
    req = (m_cnt < 4);
    check_eq("mem_rd", 32'(u_mem.mem_rd), 32'(req));
    if (req) check_eq("mem_a", u_mem.mem_a, m_pc + 32'(m_cnt));
    check_eq("if_vld", 32'(u_id.if_vld), 32'(m_vld));
    check_eq("if_is", u_id.if_is, m_vld ? word_at(m_opc) : 32'h0);
    check_eq("if_pc", u_id.if_pc, m_opc);
    if (pce) begin
      m_pc  = off + pcv;
      m_cnt = 0;
      m_vld = 1'b0;
    end else if (m_cnt < 4) begin
      if (gnt) m_cnt++;
    end else if (!m_vld) begin
      m_vld = 1'b1;
      m_opc = m_pc;
    end else if (!stall) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = 0;
      m_vld = 1'b0;
    end
  endtask

  task automatic step(input logic gnt, input logic stall, input logic pce,
                      input logic [31:0] off, input logic [31:0] pcv);
    drive_check(gnt, stall, pce, off, pcv);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    u_mem.mem_gnt = 1'b0;
    u_id.id_stall = 1'b0;
    u_id.id_if_pce = 1'b0;
    u_id.id_if_off = 32'h0;
    u_id.id_if_pc = 32'h0;
    model_reset();

    #1;
    check_eq("rst_mem_rd", 32'(u_mem.mem_rd), 32'h0);
    check_eq("rst_mem_a", u_mem.mem_a, 32'h0);
    check_eq("rst_if_vld", 32'(u_id.if_vld), 32'h0);
    check_eq("rst_if_is", u_id.if_is, 32'h0);
    check_eq("rst_if_pc", u_id.if_pc, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // first word: 5 cycles from first request to valid
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("first_vld", 32'(u_id.if_vld), 32'h1);
    check_eq("first_is", u_id.if_is, 32'h00100513);
    check_eq("first_pc", u_id.if_pc, 32'h0);
    @(negedge clk);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("next_req_a", u_mem.mem_a, 32'h4);
    @(negedge clk);

    // grant withheld for 3 cycles in REQ2
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      check_eq("nognt_a", u_mem.mem_a, 32'h6);
      check_eq("nognt_rd", 32'(u_mem.mem_rd), 32'h1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // stall held for 4 cycles in HOLD
    for (int i = 0; i < 4; i++) begin
      drive_check(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      check_eq("stall_vld", 32'(u_id.if_vld), 32'h1);
      check_eq("stall_is", u_id.if_is, word_at(32'h4));
      check_eq("stall_pc", u_id.if_pc, 32'h4);
      @(negedge clk);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("after_stall_a", u_mem.mem_a, 32'h8);
    @(negedge clk);

    // redirect during REQ2 with wrapping target
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF8);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("redir_a", u_mem.mem_a, 32'hF8);
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // redirect while stalled in HOLD discards the held word
    drive_check(1'b1, 1'b1, 1'b1, 32'h40, 32'h10);
    check_eq("redir_word_pc", u_id.if_pc, 32'hF8);
    check_eq("redir_word_is", u_id.if_is, word_at(32'hF8));
    @(negedge clk);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("hold_redir_vld", 32'(u_id.if_vld), 32'h0);
    check_eq("hold_redir_is", u_id.if_is, 32'h0);
    check_eq("hold_redir_a", u_mem.mem_a, 32'h50);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // async reset pulse in the middle of DRAIN
    drive_check(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 32'(u_id.if_vld), 32'h0);
    check_eq("mid_rst_is", u_id.if_is, 32'h0);
    check_eq("mid_rst_pc", u_id.if_pc, 32'h0);
    check_eq("mid_rst_rd", 32'(u_mem.mem_rd), 32'h0);
    check_eq("mid_rst_a", u_mem.mem_a, 32'h0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    drive_check(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("restart_a", u_mem.mem_a, 32'h0);
    @(negedge clk);

    // random grant / stall / redirect traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
